seq_divider: RTL

//  Iterative radix-2 restoring divider: 2*DATA_WIDTH dividend / DATA_WIDTH divisor -> DATA_WIDTH quotient + remainder.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 28 ++
 rtl/seq_divider.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
//   div_state_e    : divider control states (IDLE/RUN/DONE)
//   DIV_DEFAULT_W  : default operand width
//   DIV_MAX_W      : widest value the sign helper handles (2*DATA_WIDTH must fit)
//   div_cnt_w()    : step counter width for a given operand width
//   div_cond_neg() : conditional two's-complement negation (sign fixup)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_DEFAULT_W = 32;
  localparam int unsigned DIV_MAX_W     = 64;

  // Counter must hold DATA_WIDTH-1; keep at least one bit.
  function automatic int unsigned div_cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Negate v when neg is set; callers zero-extend in and truncate out.
  function automatic logic [DIV_MAX_W-1:0] div_cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                        input logic                 neg);
    return neg ? (~v + DIV_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   pr_i      : partial remainder (always < divisor)
//   dbit_i    : next dividend bit, MSB first
//   divisor_i : divisor
//   pr_o      : updated partial remainder
//   q_o       : resolved quotient bit
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   pr_i,
  input  logic                  dbit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   pr_o,
  output logic                  q_o
);

  // One extra bit above the shifted value carries the trial-subtract sign.
  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] trial;

  always_comb begin
    shifted = {pr_i, dbit_i};
    trial   = shifted - {2'b00, divisor_i};
    q_o     = ~trial[DATA_WIDTH+1];
    pr_o    = q_o ? trial[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// 2*DATA_WIDTH dividend / DATA_WIDTH divisor -> DATA_WIDTH quotient + remainder.
// Optional feature macro: DIVIDER_SIGNED_EN (two's-complement operands,
// truncating division, one extra cycle to take magnitudes).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : operand handshake (ready only when idle)
//   dividend, divisor         : operands
//   out_valid/out_ready       : result handshake, result held until taken
//   quotient, remainder       : result
//   div_by_zero, overflow     : result flags, valid with out_valid
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DEFAULT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]   remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned W2   = 2 * DATA_WIDTH;
  localparam int unsigned CntW = div_cnt_w(DATA_WIDTH);
  localparam logic [W-1:0] AllOnes = '1;
  localparam logic [W-1:0] MinNeg  = W'(1) << (W - 1);

  div_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [W:0]      pr_q;       // partial remainder
  logic [W-1:0]    lo_q;       // low dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]    dvs_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    quot_q;
  logic [W-1:0]    rem_q;
  logic            dbz_q;
  logic            ovf_q;

  logic [W:0]      pr_d;
  logic            qbit_d;
  logic [W-1:0]    q_raw_d;
  logic [W-1:0]    fin_quot_d;
  logic [W-1:0]    fin_rem_d;
  logic            fin_ovf_d;

`ifdef DIVIDER_SIGNED_EN
  logic            prep_q;     // first RUN cycle converts operands to magnitudes
  logic            neg_q_q;
  logic            neg_r_q;
  logic [W2-1:0]   mag_dvd_d;
  logic [W-1:0]    mag_dvs_d;

  // Raw signed operands sit in {pr_q[W-1:0], lo_q} and dvs_q during the prep cycle.
  always_comb begin
    mag_dvd_d = W2'(div_cond_neg(DIV_MAX_W'({pr_q[W-1:0], lo_q}), pr_q[W-1]));
    mag_dvs_d = W'(div_cond_neg(DIV_MAX_W'(dvs_q), dvs_q[W-1]));
  end
`endif

  div_step #(.DATA_WIDTH(W)) u_step (
    .pr_i      (pr_q),
    .dbit_i    (lo_q[W-1]),
    .divisor_i (dvs_q),
    .pr_o      (pr_d),
    .q_o       (qbit_d)
  );

  // Result of the final step, sign-corrected when signed operation is built in.
  always_comb begin
    q_raw_d    = {lo_q[W-2:0], qbit_d};
    fin_quot_d = q_raw_d;
    fin_rem_d  = pr_d[W-1:0];
    fin_ovf_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    fin_quot_d = W'(div_cond_neg(DIV_MAX_W'(q_raw_d), neg_q_q));
    fin_rem_d  = W'(div_cond_neg(DIV_MAX_W'(pr_d[W-1:0]), neg_r_q));
    if (neg_q_q ? (q_raw_d > MinNeg) : q_raw_d[W-1]) begin
      fin_ovf_d  = 1'b1;
      fin_quot_d = MinNeg;
      fin_rem_d  = '0;
    end
`endif
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      lo_q        <= '0;
      dvs_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      prep_q      <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              quot_q      <= AllOnes;
              rem_q       <= dividend[W-1:0];
`ifdef DIVIDER_SIGNED_EN
            end else begin
              state_q <= RUN;
              prep_q  <= 1'b1;
              pr_q    <= {1'b0, dividend[W2-1:W]};
              lo_q    <= dividend[W-1:0];
              dvs_q   <= divisor;
            end
`else
            end else if (dividend[W2-1:W] >= divisor) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              quot_q      <= AllOnes;
              rem_q       <= '0;
            end else begin
              state_q <= RUN;
              cnt_q   <= CntW'(W - 1);
              pr_q    <= {1'b0, dividend[W2-1:W]};
              lo_q    <= dividend[W-1:0];
              dvs_q   <= divisor;
            end
`endif
          end
        end

        RUN: begin
`ifdef DIVIDER_SIGNED_EN
          if (prep_q) begin
            prep_q  <= 1'b0;
            neg_q_q <= pr_q[W-1] ^ dvs_q[W-1];
            neg_r_q <= pr_q[W-1];
            // Magnitude quotient >= 2^W can never fit either signed range.
            if (mag_dvd_d[W2-1:W] >= mag_dvs_d) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              quot_q      <= MinNeg;
              rem_q       <= '0;
            end else begin
              cnt_q <= CntW'(W - 1);
              pr_q  <= {1'b0, mag_dvd_d[W2-1:W]};
              lo_q  <= mag_dvd_d[W-1:0];
              dvs_q <= mag_dvs_d;
            end
          end else begin
`else
          begin
`endif
            pr_q <= pr_d;
            lo_q <= q_raw_d;
            if (cnt_q == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dbz_q       <= 1'b0;
              ovf_q       <= fin_ovf_d;
              quot_q      <= fin_quot_d;
              rem_q       <= fin_rem_d;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
